// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide (radix-2 shift-add / restoring).
// Revision : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              c_cnt_w = $clog2(XLEN) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(XLEN - 1);
    localparam logic [1:0]      c_idle  = 2'd0;
    localparam logic [1:0]      c_calc  = 2'd1;
    localparam logic [1:0]      c_done  = 2'd2;
    localparam logic [XLEN-1:0] c_min   = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [2:0]          r_op;
    logic [2*XLEN-1:0]   r_prod;
    logic [XLEN-1:0]     r_b_mag;
    logic                r_neg;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_last;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_result;
    logic [XLEN:0]       w_sum;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_step;
    logic [2*XLEN-1:0]   w_prod_signed;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;

    assign busy   = (r_state == c_calc);
    assign done   = (r_state == c_done);
    assign result = r_result;

    assign w_accept = start && (r_state != c_calc);
    assign w_last   = (r_cnt == c_last);

    // Operand decode: a signed for MULH/MULHSU/DIV/REM, b signed for MULH/DIV/REM.
    assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op[2] && !op[0]);
    assign w_b_signed = (op == 3'b001) || (op[2] && !op[0]);
    assign w_a_neg    = w_a_signed && a[XLEN-1];
    assign w_b_neg    = w_b_signed && b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag    = w_b_neg ? (~b + 1'b1) : b;

    assign w_div_zero    = op[2] && (b == '0);
    assign w_ovf         = op[2] && !op[0] && (a == c_min) && (b == '1);
    assign w_fast        = w_div_zero || w_ovf;
    assign w_fast_result = w_div_zero ? (op[1] ? a : '1)
                                      : (op[1] ? '0 : a);

    // Multiply: multiplier sits in the low half and shifts out LSB first.
    assign w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]}
                      + (r_prod[0] ? {1'b0, r_b_mag} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_sum, r_prod[XLEN-1:1]};

    // Divide: high half is the partial remainder, low half dividend/quotient.
    assign w_rem_sh   = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_b_mag};
    assign w_div_next = w_diff[XLEN]
                      ? {w_rem_sh[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                      : {w_diff[XLEN-1:0],   r_prod[XLEN-2:0], 1'b1};

    assign w_step        = r_op[2] ? w_div_next : w_mul_next;
    assign w_prod_signed = r_neg ? (~w_step + 1'b1) : w_step;
    assign w_quo         = r_neg ? (~w_step[XLEN-1:0] + 1'b1) : w_step[XLEN-1:0];
    assign w_rem         = r_neg ? (~w_step[2*XLEN-1:XLEN] + 1'b1)
                                 : w_step[2*XLEN-1:XLEN];

    always_comb begin
        w_final = w_prod_signed[2*XLEN-1:XLEN];
        if (!r_op[2]) begin
            if (r_op[1:0] == 2'b00) w_final = w_prod_signed[XLEN-1:0];
        end else if (r_op[1]) begin
            w_final = w_rem;
        end else begin
            w_final = w_quo;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_calc:  if (w_last) w_state_next = c_done;
            default: begin
                if (start) w_state_next = w_fast ? c_done : c_calc;
                else       w_state_next = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_idle;
            r_op     <= '0;
            r_prod   <= '0;
            r_b_mag  <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op    <= op;
                r_prod  <= {{XLEN{1'b0}}, w_a_mag};
                r_b_mag <= w_b_mag;
                // Remainder follows the dividend; everything else uses the XOR.
                r_neg   <= (op[2] && op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
                r_cnt   <= '0;
                if (w_fast) r_result <= w_fast_result;
            end else if (r_state == c_calc) begin
                r_prod <= w_step;
                r_cnt  <= r_cnt + 1'b1;
                if (w_last) r_result <= w_final;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit (XLEN = 32).
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;

    localparam logic [2:0] c_mul = 3'b000, c_mulh = 3'b001, c_mulhsu = 3'b010,
                           c_mulhu = 3'b011, c_div = 3'b100, c_divu = 3'b101,
                           c_rem = 3'b110, c_remu = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Drives one request; returns #1 into cycle E0+1 with operands scrambled.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    endtask

    // Counts cycles from E0+1 until done (bounded); lat = -1 on timeout.
    task automatic wait_done(output int lat, output int nbusy, output int nboth);
        lat = -1; nbusy = 0; nboth = 0;
        for (int k = 1; k <= 100; k++) begin
            if (busy && done) nboth++;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mul();
        int lat, nb, nboth;
        issue(c_mul, 32'd7, 32'hFFFFFFFD);
        wait_done(lat, nb, nboth);
        total++; if (lat !== 33) begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
        total++; if (nb !== 32) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=32", nb); end
        total++; if (nboth !== 0) begin bad++; $display("FAIL mul_busy_and_done got=%0d want=0", nboth); end
        total++; if (result !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_result got=%h want=ffffffeb", result); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_one_cycle got=%b want=0", done); end
        total++; if (result !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_result_hold got=%h want=ffffffeb", result); end
    endtask

    task automatic test_mulhigh();
        logic [2:0]  ops [3] = '{c_mulh, c_mulhu, c_mulhsu};
        logic [31:0] xs  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ys  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        int lat, nb, nboth;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], xs[i], ys[i]);
            wait_done(lat, nb, nboth);
            total++;
            if (lat !== 33 || result !== exp[i]) begin
                bad++; $display("FAIL mulhigh_%0d got=%h lat=%0d want=%h lat=33", i, result, lat, exp[i]);
            end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  ops [4] = '{c_div, c_rem, c_divu, c_remu};
        logic [31:0] xs  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] ys  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        int lat, nb, nboth;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], xs[i], ys[i]);
            wait_done(lat, nb, nboth);
            total++;
            if (lat !== 33 || nb !== 32 || result !== exp[i]) begin
                bad++; $display("FAIL divide_%0d got=%h lat=%0d busy=%0d want=%h lat=33 busy=32", i, result, lat, nb, exp[i]);
            end
        end
    endtask

    task automatic test_corner();
        logic [2:0]  ops [6] = '{c_divu, c_rem, c_div, c_remu, c_div, c_rem};
        logic [31:0] xs  [6] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] ys  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [6] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int lat, nb, nboth;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], xs[i], ys[i]);
            wait_done(lat, nb, nboth);
            total++;
            if (lat !== 1 || nb !== 0 || result !== exp[i]) begin
                bad++; $display("FAIL corner_%0d got=%h lat=%0d busy=%0d want=%h lat=1 busy=0", i, result, lat, nb, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb, nboth;
        issue(c_mul, 32'd3, 32'd5);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 5) begin op = c_mulhu; a = 32'd1000; b = 32'd1000; start = 1'b1; end
            if (k == 9) start = 1'b0;
            if (done) begin lat = k; break; end
            @(posedge clk); #1;
        end
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_first_latency got=%0d want=33", lat); end
        total++; if (result !== 32'd15) begin bad++; $display("FAIL b2b_first_result got=%0d want=15", result); end
        // Request presented inside the DONE cycle.
        op = c_divu; a = 32'd9; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'd77; b = 32'd0;
        wait_done(lat, nb, nboth);
        total++; if (lat !== 33 || nb !== 32) begin bad++; $display("FAIL b2b_second_timing got lat=%0d busy=%0d want lat=33 busy=32", lat, nb); end
        total++; if (result !== 32'd3) begin bad++; $display("FAIL b2b_second_result got=%0d want=3", result); end
    endtask

    task automatic test_reset_mid();
        int lat, nb, nboth, ndone;
        issue(c_mul, 32'd11, 32'd13);
        repeat (9) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", busy); end
        #2 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rmid_async_flags got busy=%b done=%b want 0 0", busy, done); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL rmid_async_result got=%h want=0", result); end
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (done || busy) ndone++; end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rmid_discarded got=%0d active cycles want=0", ndone); end
        issue(c_mul, 32'd6, 32'd7);
        wait_done(lat, nb, nboth);
        total++; if (lat !== 33 || result !== 32'd42) begin bad++; $display("FAIL rmid_after got=%0d lat=%0d want=42 lat=33", result, lat); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulhigh();
        test_divide();
        test_corner();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
